grant_requester: RTL

//  Requester-side agent for the 3-bit request / 2-bit encoded grant interface of the priority arbiter.

---
 rtl/grant_req_pkg.sv | 32 +++
 rtl/grant_req_client.sv | 73 +++++++
 rtl/grant_requester.sv | 89 ++++++++
 3 files changed

// File: rtl/grant_req_pkg.sv
// Shared types for the grant requester.
//   grant_code_t   : 2-bit encoded grant from the priority arbiter
//   client_state_t : per-client request state
//   grant_onehot() : decodes a grant code to a one-hot client select
package grant_req_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_C0   = 2'b01,
        GNT_C1   = 2'b10,
        GNT_C2   = 2'b11
    } grant_code_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PEND = 2'b01,
        ST_ACK  = 2'b10
    } client_state_t;

    // The 2-bit grant encoding only has room for three clients.
    localparam int unsigned GRANT_CLIENTS = 3;

    function automatic logic [2:0] grant_onehot(input grant_code_t code);
        case (code)
            GNT_C0:  return 3'b001;
            GNT_C1:  return 3'b010;
            GNT_C2:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/grant_req_client.sv
// One requester slot: IDLE/PEND/ACK state machine, saturating wait counter
// and starvation flag for a single client.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : one-cycle request pulse from the client
//   sel        : the grant sampled this cycle targets this client
//   pend       : request line to the arbiter (state is PEND)
//   ack        : one-cycle acknowledge to the client (state is ACK)
//   starve     : pending for MAX_WAIT or more cycles
module grant_req_client
    import grant_req_pkg::*;
#(
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic sel,
    output logic pend,
    output logic ack,
    output logic starve
);

    client_state_t     state, state_nxt;
    logic [WAIT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = ST_PEND;
                    cnt_nxt   = '0;
                end
            end
            ST_PEND: begin
                // Further request pulses while pending are coalesced.
                if (sel) begin
                    state_nxt = ST_ACK;
                end else if (cnt != WAIT_W'(MAX_WAIT)) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_ACK: begin
                // A pulse arriving during the ack cycle re-arms immediately so it is not lost.
                if (req) begin
                    state_nxt = ST_PEND;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign pend   = (state == ST_PEND);
    assign ack    = (state == ST_ACK);
    assign starve = pend && (cnt == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/grant_requester.sv
// Requester-side agent for the priority arbiter: turns client request pulses
// into sticky request lines, decodes the arbiter's encoded grant into
// one-cycle client acks, and flags clients that wait too long.
// Optional feature macro: GRANT_REQ_ERR_CHECK_EN enables the sticky
// illegal-grant flag; without it grant_err is tied low.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   client_req  : one-cycle request pulse per client (bit0 highest priority)
//   request     : sticky request lines to the arbiter
//   grant       : encoded grant (00 none, 01/10/11 client 0/1/2)
//   client_ack  : one-cycle ack to the granted client
//   starve      : per-client starvation flag
//   grant_err   : sticky flag for a grant aimed at a non-pending client
module grant_requester
    import grant_req_pkg::*;
#(
    parameter int NUM_CLIENTS = 3,
    parameter int WAIT_W      = 4,
    parameter int MAX_WAIT    = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CLIENTS-1:0] client_req,
    output logic [NUM_CLIENTS-1:0] request,
    input  logic [1:0]             grant,
    output logic [NUM_CLIENTS-1:0] client_ack,
    output logic [NUM_CLIENTS-1:0] starve,
    output logic                   grant_err
);

    if (NUM_CLIENTS != GRANT_CLIENTS) begin : g_bad_clients
        $error("grant_requester: NUM_CLIENTS must be 3 for a 2-bit grant code");
    end
    if (MAX_WAIT >= (2 ** WAIT_W)) begin : g_bad_wait
        $error("grant_requester: MAX_WAIT must fit in WAIT_W bits");
    end

    grant_code_t            code;
    logic [NUM_CLIENTS-1:0] sel;

    // The client FSMs sample the select on the clock edge, which is what
    // registers the grant and gives the one-cycle grant-to-ack latency.
    assign code = grant_code_t'(grant);
    assign sel  = grant_onehot(code);

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_client
        grant_req_client #(
            .WAIT_W   (WAIT_W),
            .MAX_WAIT (MAX_WAIT)
        ) u_client (
            .clk    (clk),
            .rst_n  (rst_n),
            .req    (client_req[i]),
            .sel    (sel[i]),
            .pend   (request[i]),
            .ack    (client_ack[i]),
            .starve (starve[i])
        );
    end

`ifdef GRANT_REQ_ERR_CHECK_EN
    logic illegal;
    logic err_q;

    // Nonzero grant whose target is not currently pending.
    assign illegal = (code != GNT_NONE) && ((sel & request) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (illegal) begin
            err_q <= 1'b1;
        end
    end

    assign grant_err = err_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && illegal) begin
            $error("grant_requester: illegal grant %b at time %0t", grant, $time);
        end
    end
`endif
`else
    assign grant_err = 1'b0;
`endif

endmodule
